// File: rtl/dispatch_int_queue.sv
// dispatch_int_queue: in-order 2-in/2-out uop buffer between dispatch and integer Dispatch2Rs
module dispatch_int_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     io_enq_canAccept,
    input  logic                     io_enq_req_0_valid,
    input  logic [3:0]               io_enq_req_0_bits_fuType,
    input  logic [DATA_W-1:0]        io_enq_req_0_bits_data,
    input  logic                     io_enq_req_1_valid,
    input  logic [3:0]               io_enq_req_1_bits_fuType,
    input  logic [DATA_W-1:0]        io_enq_req_1_bits_data,
    output logic                     io_out_0_valid,
    output logic [3:0]               io_out_0_bits_fuType,
    output logic [DATA_W-1:0]        io_out_0_bits_data,
    input  logic                     io_out_0_ready,
    output logic                     io_out_1_valid,
    output logic [3:0]               io_out_1_bits_fuType,
    output logic [DATA_W-1:0]        io_out_1_bits_data,
    input  logic                     io_out_1_ready,
    input  logic                     io_redirect_valid,
    output logic [$clog2(DEPTH):0]   io_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [3:0]        fu_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     enq_ptr, deq_ptr, enq_ptr_1, deq_ptr_1;
    logic [PW-1:0]     count, count_next, n_enq, n_deq;
    logic              enq_en, fire0, fire1;

    assign count     = enq_ptr - deq_ptr;
    assign io_count  = count;
    assign deq_ptr_1 = deq_ptr + PW'(1);
    assign enq_ptr_1 = enq_ptr + PW'(io_enq_req_0_valid);

    assign io_out_0_valid       = !io_redirect_valid && count != '0;
    assign io_out_1_valid       = !io_redirect_valid && count >= PW'(2);
    assign io_out_0_bits_fuType = fu_mem[deq_ptr[AW-1:0]];
    assign io_out_0_bits_data   = data_mem[deq_ptr[AW-1:0]];
    assign io_out_1_bits_fuType = fu_mem[deq_ptr_1[AW-1:0]];
    assign io_out_1_bits_data   = data_mem[deq_ptr_1[AW-1:0]];

    // lane 1 can only retire alongside lane 0, so order is preserved
    assign fire0 = io_out_0_valid && io_out_0_ready;
    assign fire1 = fire0 && io_out_1_valid && io_out_1_ready;

    assign enq_en     = io_enq_canAccept && !io_redirect_valid;
    assign n_enq      = enq_en ? PW'(io_enq_req_0_valid) + PW'(io_enq_req_1_valid) : '0;
    assign n_deq      = PW'(fire0) + PW'(fire1);
    assign count_next = io_redirect_valid ? '0 : count + n_enq - n_deq;

    // payload storage: compacted in-order writes, no reset
    always_ff @(posedge clock) begin
        if (enq_en && io_enq_req_0_valid) begin
            fu_mem[enq_ptr[AW-1:0]]   <= io_enq_req_0_bits_fuType;
            data_mem[enq_ptr[AW-1:0]] <= io_enq_req_0_bits_data;
        end
        if (enq_en && io_enq_req_1_valid) begin
            fu_mem[enq_ptr_1[AW-1:0]]   <= io_enq_req_1_bits_fuType;
            data_mem[enq_ptr_1[AW-1:0]] <= io_enq_req_1_bits_data;
        end
    end

    // pointers and registered accept flag; redirect empties the queue
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enq_ptr          <= '0;
            deq_ptr          <= '0;
            io_enq_canAccept <= 1'b1;
        end else begin
            enq_ptr          <= io_redirect_valid ? '0 : enq_ptr + n_enq;
            deq_ptr          <= io_redirect_valid ? '0 : deq_ptr + n_deq;
            io_enq_canAccept <= count_next <= PW'(DEPTH - 2);
        end
    end
endmodule

// File: tb/tb_dispatch_int_queue.sv
// tb_dispatch_int_queue: scoreboard bench for dispatch_int_queue with directed vectors
module tb_dispatch_int_queue;
    logic        clock = 0, reset = 0;
    logic        can_accept;
    logic        v0 = 0, v1 = 0, r0 = 0, r1 = 0, redir = 0;
    logic [3:0]  f0 = 0, f1 = 0, of0, of1;
    logic [31:0] d0 = 0, d1 = 0, od0, od1;
    logic        ov0, ov1;
    logic [3:0]  cnt;
    int          tests = 0, fails = 0;
    logic [35:0] sb [$];
    int          seq = 0;

    dispatch_int_queue #(.DEPTH(8), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .io_enq_canAccept(can_accept),
        .io_enq_req_0_valid(v0), .io_enq_req_0_bits_fuType(f0), .io_enq_req_0_bits_data(d0),
        .io_enq_req_1_valid(v1), .io_enq_req_1_bits_fuType(f1), .io_enq_req_1_bits_data(d1),
        .io_out_0_valid(ov0), .io_out_0_bits_fuType(of0), .io_out_0_bits_data(od0), .io_out_0_ready(r0),
        .io_out_1_valid(ov1), .io_out_1_bits_fuType(of1), .io_out_1_bits_data(od1), .io_out_1_ready(r1),
        .io_redirect_valid(redir), .io_count(cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [3:0] f, input logic [31:0] d);
        if (sb.size() == 0) chk({name, "_sb_empty"}, {f, d}, 64'hDEAD);
        else chk(name, {f, d}, sb.pop_front());
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (ov0 && r0) pop_chk("out0", of0, od0);
            if (ov0 && r0 && ov1 && r1) pop_chk("out1", of1, od1);
        end
    endtask

    // drive one cycle of stimulus; acc is the hand-known acceptance of this enqueue
    task automatic drive(input logic a0, input logic a1, input logic acc,
                         input logic q0, input logic q1, input logic rd);
        v0 = a0; v1 = a1; r0 = q0; r1 = q1; redir = rd;
        f0 = 4'(seq % 16); d0 = 32'hA000_0000 + 32'(seq);
        f1 = 4'((seq + 1) % 16); d1 = 32'hA000_0000 + 32'(seq + 1);
        if (rd) sb.delete();
        else if (acc) begin
            if (a0) sb.push_back({f0, d0});
            if (a1) sb.push_back({f1, d1});
        end
        seq += 2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic a0, input logic a1, input logic acc,
                        input logic q0, input logic q1, input logic rd);
        drive(a0, a1, acc, q0, q1, rd);
        tick();
    endtask

    initial begin
        fork monitor(); join_none
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", cnt, 0);
        chk("rst_can", can_accept, 1);
        chk("rst_ov0", ov0, 0);
        chk("rst_ov1", ov1, 0);
        reset = 1;
        tick();
        // only lane 1 valid into empty queue
        v1 = 1; f1 = 4'h5; d1 = 32'h5555_0001; sb.push_back({4'h5, 32'h5555_0001});
        tick();
        v1 = 0;
        chk("l1_count", cnt, 1);
        chk("l1_ov0", ov0, 1);
        chk("l1_ov1", ov1, 0);
        chk("l1_fu", of0, 4'h5);
        step(0, 0, 0, 1, 1, 0);
        chk("l1_drain", cnt, 0);
        // fill with outputs stalled
        step(1, 1, 1, 0, 0, 0); chk("fill_c2", cnt, 2); chk("fill_a2", can_accept, 1);
        step(1, 1, 1, 0, 0, 0); chk("fill_c4", cnt, 4); chk("fill_a4", can_accept, 1);
        step(1, 1, 1, 0, 0, 0); chk("fill_c6", cnt, 6); chk("fill_a6", can_accept, 1);
        step(1, 1, 1, 0, 0, 0); chk("fill_c8", cnt, 8); chk("fill_a8", can_accept, 0);
        step(1, 1, 0, 0, 0, 0); chk("full_hold", cnt, 8);
        step(0, 0, 0, 0, 1, 0); chk("l1_only_ready", cnt, 8);
        step(0, 0, 0, 1, 1, 0); chk("deq2_count", cnt, 6); chk("deq2_can", can_accept, 1);
        step(0, 0, 0, 1, 1, 0); chk("drain4", cnt, 4);
        step(0, 0, 0, 1, 1, 0); chk("drain2", cnt, 2);
        // steady 2-in/2-out across pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1, 1, 1, 0);
            chk($sformatf("wrap_c%0d", i), cnt, 2);
        end
        step(0, 0, 0, 1, 1, 0); chk("wrap_drain", cnt, 0);
        chk("wrap_sb", sb.size(), 0);
        // redirect with enqueue 2 / dequeue 1 at count 4
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0); chk("pre_redir", cnt, 4);
        drive(1, 1, 0, 1, 0, 1);
        #2;
        chk("redir_ov0", ov0, 0);
        chk("redir_ov1", ov1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("post_redir_c", cnt, 0);
        chk("post_redir_a", can_accept, 1);
        chk("post_redir_ov0", ov0, 0);
        chk("post_redir_ov1", ov1, 0);
        tick();
        // short reset pulse with count 5
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0); chk("pre_rst", cnt, 5);
        drive(0, 0, 0, 1, 1, 0);
        reset = 0;
        sb.delete();
        #1;
        chk("arst_ov0", ov0, 0);
        chk("arst_ov1", ov1, 0);
        chk("arst_count", cnt, 0);
        #1 reset = 1;
        #1 chk("arst_can", can_accept, 1);
        tick();
        chk("post_rst_ov0", ov0, 0);
        chk("post_rst_count", cnt, 0);
        step(1, 0, 1, 1, 1, 0); chk("post_rst_c1", cnt, 1);
        step(0, 0, 0, 1, 1, 0); chk("post_rst_c0", cnt, 0);
        chk("final_sb", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
